// File: rtl/tnoc_flit_slicer_multimode.sv
// Per-virtual-channel flit pipeline slicer: combinational bypass, forward register,
// or full 2-entry skid slice selected at elaboration by MODE.
module tnoc_flit_slicer_multimode #(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned MODE       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
    output logic [CHANNELS-1:0]            o_valid,
    input  logic [CHANNELS-1:0]            i_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
    output logic [2*CHANNELS-1:0]          o_count,
    output logic [CHANNELS-1:0]            o_empty
);

    generate
        if (MODE == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, i_clear};

            assign o_valid = i_valid;
            assign o_flit  = i_flit;
            assign o_ready = i_ready;
            assign o_count = '0;
            assign o_empty = '1;
        end else if (MODE == 1) begin : g_fwd
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                logic                  full_q;
                logic [FLIT_WIDTH-1:0] data_q;
                logic                  ready;
                logic                  valid;
                logic                  push;
                logic                  pop;

                // Ready may look through to i_ready: a pop frees the single slot this cycle.
                assign ready = ~rst & ~i_clear & (~full_q | i_ready[c]);
                assign valid = full_q & ~rst;
                assign push  = i_valid[c] & ready;
                assign pop   = valid & i_ready[c];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        full_q <= 1'b0;
                        data_q <= '0;
                    end else if (i_clear) begin
                        full_q <= 1'b0;
                    end else if (push) begin
                        full_q <= 1'b1;
                        data_q <= i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
                    end else if (pop) begin
                        full_q <= 1'b0;
                    end
                end

                assign o_ready[c]                          = ready;
                assign o_valid[c]                          = valid;
                assign o_flit[c*FLIT_WIDTH +: FLIT_WIDTH]  = data_q;
                assign o_count[2*c +: 2]                   = {1'b0, valid};
                assign o_empty[c]                          = ~valid;
            end
        end else begin : g_skid
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                logic [1:0]            cnt_q;
                logic [1:0]            cnt_d;
                logic                  rdy_q;
                logic [FLIT_WIDTH-1:0] head_q;
                logic [FLIT_WIDTH-1:0] skid_q;
                logic                  ready;
                logic                  valid;
                logic                  push;
                logic                  pop;

                // rdy_q is a flop, so i_ready never reaches o_ready combinationally.
                assign ready = rdy_q & ~rst & ~i_clear;
                assign valid = (cnt_q != 2'd0) & ~rst;
                assign push  = i_valid[c] & ready;
                assign pop   = valid & i_ready[c];

                always_comb begin
                    cnt_d = cnt_q;
                    unique case ({push, pop})
                        2'b10:   cnt_d = cnt_q + 2'd1;
                        2'b01:   cnt_d = cnt_q - 2'd1;
                        default: cnt_d = cnt_q;
                    endcase
                    if (i_clear) begin
                        cnt_d = 2'd0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt_q  <= 2'd0;
                        rdy_q  <= 1'b1;
                        head_q <= '0;
                        skid_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        rdy_q <= (cnt_d != 2'd2);
                        if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
                            head_q <= i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
                        end else if (pop && cnt_q == 2'd2) begin
                            head_q <= skid_q;
                        end
                        if (push && cnt_q == 2'd1 && !pop) begin
                            skid_q <= i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
                        end
                    end
                end

                assign o_ready[c]                          = ready;
                assign o_valid[c]                          = valid;
                assign o_flit[c*FLIT_WIDTH +: FLIT_WIDTH]  = head_q;
                assign o_count[2*c +: 2]                   = rst ? 2'd0 : cnt_q;
                assign o_empty[c]                          = ~valid;
            end
        end
    endgenerate

endmodule

// File: tb/tb_tnoc_flit_slicer_multimode.sv
// Bench for tnoc_flit_slicer_multimode: one instance per MODE sharing the same stimulus,
// directed scenarios plus randomized traffic against queue-based reference models.
module tb_tnoc_flit_slicer_multimode;

    localparam int FW = 8;
    localparam int CH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [1:0]  iv;
    logic [1:0]  ir;
    logic [15:0] fl;

    logic [1:0]  v0, r0, e0, v1, r1, e1, v2, r2, e2;
    logic [15:0] f0, f1, f2;
    logic [3:0]  c0, c1, c2;

    int checks = 0;
    int errors = 0;

    logic [7:0] q1 [2][$];
    logic [7:0] q2 [2][$];

    always #5 clk = ~clk;

    tnoc_flit_slicer_multimode #(.FLIT_WIDTH(FW), .CHANNELS(CH), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .i_clear(clr), .i_valid(iv), .o_ready(r0), .i_flit(fl),
        .o_valid(v0), .i_ready(ir), .o_flit(f0), .o_count(c0), .o_empty(e0)
    );

    tnoc_flit_slicer_multimode #(.FLIT_WIDTH(FW), .CHANNELS(CH), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .i_clear(clr), .i_valid(iv), .o_ready(r1), .i_flit(fl),
        .o_valid(v1), .i_ready(ir), .o_flit(f1), .o_count(c1), .o_empty(e1)
    );

    tnoc_flit_slicer_multimode #(.FLIT_WIDTH(FW), .CHANNELS(CH), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .i_clear(clr), .i_valid(iv), .o_ready(r2), .i_flit(fl),
        .o_valid(v2), .i_ready(ir), .o_flit(f2), .o_count(c2), .o_empty(e2)
    );

    // An occupancy of 3 can never be legal in the skid build.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (c2[2*c +: 2] === 2'd3) begin
                    errors++;
                    $display("FAIL count_range ch%0d got %0d exp <=2", c, c2[2*c +: 2]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; iv = 2'b00; ir = 2'b00; fl = 16'h0000;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; iv = 2'b11; ir = 2'b10; fl = 16'h3C5A;
        for (int k = 0; k < 2; k++) begin
            smp();
            checks++;
            if ({v2, r2, c2, e2} !== {2'b00, 2'b00, 4'h0, 2'b11}) begin
                errors++;
                $display("FAIL reset_m2 got %b exp %b", {v2, r2, c2, e2}, 10'b0000000011);
            end
            checks++;
            if ({v1, r1, c1, e1} !== {2'b00, 2'b00, 4'h0, 2'b11}) begin
                errors++;
                $display("FAIL reset_m1 got %b exp %b", {v1, r1, c1, e1}, 10'b0000000011);
            end
            checks++;
            if ({v0, r0, f0} !== {iv, ir, fl}) begin
                errors++;
                $display("FAIL reset_m0 got %h exp %h", {v0, r0, f0}, {iv, ir, fl});
            end
            next();
        end
        rst = 1'b0; iv = 2'b00; ir = 2'b00;
        smp();
        checks++;
        if ({v2, r2, c2, e2} !== {2'b00, 2'b11, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL post_reset_m2 got %b exp %b", {v2, r2, c2, e2}, 10'b0011000011);
        end
        checks++;
        if ({v1, r1, c1, e1} !== {2'b00, 2'b11, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL post_reset_m1 got %b exp %b", {v1, r1, c1, e1}, 10'b0011000011);
        end
        next();
    endtask

    task automatic test_stream();
        logic ev;
        do_reset();
        ir = 2'b11;
        for (int k = 0; k <= 16; k++) begin
            iv = (k < 16) ? 2'b01 : 2'b00;
            fl = {8'h00, 8'(k + 1)};
            smp();
            ev = (k >= 1);
            checks++;
            if ({v2[0], r2[0], c2[1:0]} !== {ev, 1'b1, 1'b0, ev}) begin
                errors++;
                $display("FAIL stream_m2 cyc%0d got %b exp %b", k, {v2[0], r2[0], c2[1:0]},
                         {ev, 1'b1, 1'b0, ev});
            end
            checks++;
            if ({v1[0], r1[0], c1[1:0]} !== {ev, 1'b1, 1'b0, ev}) begin
                errors++;
                $display("FAIL stream_m1 cyc%0d got %b exp %b", k, {v1[0], r1[0], c1[1:0]},
                         {ev, 1'b1, 1'b0, ev});
            end
            if (ev) begin
                checks++;
                if ({f2[7:0], f1[7:0]} !== {8'(k), 8'(k)}) begin
                    errors++;
                    $display("FAIL stream_flit cyc%0d got %h exp %h", k, {f2[7:0], f1[7:0]},
                             {8'(k), 8'(k)});
                end
            end
            next();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ir = 2'b00; iv = 2'b01; fl = 16'h00A1;
        smp();
        checks++;
        if (r2[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready0 got %b exp 1", r2[0]);
        end
        next();
        fl = 16'h00A2;
        smp();
        checks++;
        if ({v2[0], r2[0], c2[1:0], f2[7:0]} !== {1'b1, 1'b1, 2'd1, 8'hA1}) begin
            errors++;
            $display("FAIL bp_one got %h exp %h", {v2[0], r2[0], c2[1:0], f2[7:0]}, 12'hDA1);
        end
        next();
        iv = 2'b10; ir = 2'b10; fl = 16'h5500;
        smp();
        checks++;
        if ({v2[0], r2[0], c2[1:0], f2[7:0]} !== {1'b1, 1'b0, 2'd2, 8'hA1}) begin
            errors++;
            $display("FAIL bp_full got %h exp %h", {v2[0], r2[0], c2[1:0], f2[7:0]}, 12'hAA1);
        end
        checks++;
        if ({v2[1], r2[1], c2[3:2]} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL bp_ch1_idle got %b exp 0100", {v2[1], r2[1], c2[3:2]});
        end
        next();
        fl = 16'h6600;
        smp();
        checks++;
        if ({v2[1], c2[3:2], f2[15:8], v2[0], f2[7:0]} !== {1'b1, 2'd1, 8'h55, 1'b1, 8'hA1}) begin
            errors++;
            $display("FAIL bp_ch1_55 got %h exp %h", {v2[1], c2[3:2], f2[15:8], v2[0], f2[7:0]},
                     {1'b1, 2'd1, 8'h55, 1'b1, 8'hA1});
        end
        next();
        iv = 2'b00;
        smp();
        checks++;
        if ({v2[1], f2[15:8], c2[1:0], f2[7:0]} !== {1'b1, 8'h66, 2'd2, 8'hA1}) begin
            errors++;
            $display("FAIL bp_ch1_66 got %h exp %h", {v2[1], f2[15:8], c2[1:0], f2[7:0]},
                     {1'b1, 8'h66, 2'd2, 8'hA1});
        end
        next();
        ir = 2'b01;
        smp();
        checks++;
        if ({r2[0], c2[1:0], f2[7:0], v2[1]} !== {1'b0, 2'd2, 8'hA1, 1'b0}) begin
            errors++;
            $display("FAIL bp_no_comb_ready got %h exp %h", {r2[0], c2[1:0], f2[7:0], v2[1]},
                     {1'b0, 2'd2, 8'hA1, 1'b0});
        end
        next();
        ir = 2'b00;
        smp();
        checks++;
        if ({v2[0], r2[0], c2[1:0], f2[7:0]} !== {1'b1, 1'b1, 2'd1, 8'hA2}) begin
            errors++;
            $display("FAIL bp_after_pop got %h exp %h", {v2[0], r2[0], c2[1:0], f2[7:0]},
                     {1'b1, 1'b1, 2'd1, 8'hA2});
        end
        next();
    endtask

    task automatic test_mode1_toggle();
        logic [7:0] q[$];
        logic [7:0] nxt;
        logic       er;
        logic       ev;
        do_reset();
        nxt = 8'h10; iv = 2'b01;
        for (int k = 0; k < 14; k++) begin
            ir = {1'b0, (k % 2) == 0};
            fl = {8'h00, nxt};
            smp();
            er = (q.size() == 0) || ir[0];
            ev = (q.size() != 0);
            checks++;
            if ({v1[0], r1[0], c1[1:0]} !== {ev, er, 1'b0, ev}) begin
                errors++;
                $display("FAIL m1_toggle cyc%0d got %b exp %b", k, {v1[0], r1[0], c1[1:0]},
                         {ev, er, 1'b0, ev});
            end
            if (ev) begin
                checks++;
                if (f1[7:0] !== q[0]) begin
                    errors++;
                    $display("FAIL m1_toggle_flit cyc%0d got %h exp %h", k, f1[7:0], q[0]);
                end
                if (ir[0]) void'(q.pop_front());
            end
            if (er) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            next();
        end
    endtask

    task automatic test_clear();
        do_reset();
        ir = 2'b00; iv = 2'b11; fl = 16'hB1A1;
        next();
        fl = 16'hB2A2;
        next();
        clr = 1'b1; fl = 16'hC2C1;
        smp();
        checks++;
        if ({v2, r2, c2} !== {2'b11, 2'b00, 4'b1010}) begin
            errors++;
            $display("FAIL clear_cycle_m2 got %b exp %b", {v2, r2, c2}, 8'b11001010);
        end
        checks++;
        if (r1 !== 2'b00) begin
            errors++;
            $display("FAIL clear_cycle_m1 got %b exp 00", r1);
        end
        next();
        clr = 1'b0; iv = 2'b00;
        smp();
        checks++;
        if ({v2, r2, c2, e2} !== {2'b00, 2'b11, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL after_clear_m2 got %b exp %b", {v2, r2, c2, e2}, 10'b0011000011);
        end
        checks++;
        if ({v1, c1, e1} !== {2'b00, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL after_clear_m1 got %b exp %b", {v1, c1, e1}, 8'b00000011);
        end
        next();
        smp();
        checks++;
        if (v2 !== 2'b00) begin
            errors++;
            $display("FAIL clear_no_accept got %b exp 00", v2);
        end
        next();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        ir = 2'b11; iv = 2'b01; fl = 16'h0021;
        next();
        fl = 16'h0022;
        next();
        rst = 1'b1; fl = 16'h0023;
        for (int k = 0; k < 2; k++) begin
            smp();
            checks++;
            if ({v2, r2, c2, e2} !== {2'b00, 2'b00, 4'h0, 2'b11}) begin
                errors++;
                $display("FAIL mid_reset cyc%0d got %b exp %b", k, {v2, r2, c2, e2},
                         10'b0000000011);
            end
            next();
        end
        rst = 1'b0; iv = 2'b00;
        smp();
        checks++;
        if ({v2, r2, c2, e2} !== {2'b00, 2'b11, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL mid_reset_after got %b exp %b", {v2, r2, c2, e2}, 10'b0011000011);
        end
        next();
    endtask

    task automatic test_mode0();
        for (int k = 0; k < 20; k++) begin
            rst = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            iv = 2'($urandom); ir = 2'($urandom); fl = 16'($urandom);
            smp();
            checks++;
            if ({v0, r0, f0, c0, e0} !== {iv, ir, fl, 4'h0, 2'b11}) begin
                errors++;
                $display("FAIL mode0 cyc%0d got %h exp %h", k, {v0, r0, f0, c0, e0},
                         {iv, ir, fl, 4'h0, 2'b11});
            end
            next();
        end
    endtask

    task automatic test_random();
        int   n1, n2;
        logic er1, ev1, er2, ev2;
        do_reset();
        for (int c = 0; c < CH; c++) begin
            q1[c].delete();
            q2[c].delete();
        end
        for (int k = 0; k < 400; k++) begin
            iv = 2'($urandom); ir = 2'($urandom); fl = 16'($urandom);
            clr = ($urandom_range(0, 31) == 0);
            smp();
            for (int c = 0; c < CH; c++) begin
                n2 = q2[c].size(); er2 = !clr && (n2 < 2); ev2 = (n2 != 0);
                n1 = q1[c].size(); er1 = !clr && (n1 == 0 || ir[c]); ev1 = (n1 != 0);
                checks++;
                if ({v2[c], r2[c], c2[2*c +: 2], e2[c]} !== {ev2, er2, 2'(n2), n2 == 0}) begin
                    errors++;
                    $display("FAIL rnd_m2 cyc%0d ch%0d got %b exp %b", k, c,
                             {v2[c], r2[c], c2[2*c +: 2], e2[c]}, {ev2, er2, 2'(n2), n2 == 0});
                end
                checks++;
                if ({v1[c], r1[c], c1[2*c +: 2], e1[c]} !== {ev1, er1, 2'(n1), n1 == 0}) begin
                    errors++;
                    $display("FAIL rnd_m1 cyc%0d ch%0d got %b exp %b", k, c,
                             {v1[c], r1[c], c1[2*c +: 2], e1[c]}, {ev1, er1, 2'(n1), n1 == 0});
                end
                if (ev2) begin
                    checks++;
                    if (f2[8*c +: 8] !== q2[c][0]) begin
                        errors++;
                        $display("FAIL rnd_m2_flit cyc%0d ch%0d got %h exp %h", k, c,
                                 f2[8*c +: 8], q2[c][0]);
                    end
                end
                if (ev1) begin
                    checks++;
                    if (f1[8*c +: 8] !== q1[c][0]) begin
                        errors++;
                        $display("FAIL rnd_m1_flit cyc%0d ch%0d got %h exp %h", k, c,
                                 f1[8*c +: 8], q1[c][0]);
                    end
                end
                if (clr) begin
                    q2[c].delete();
                    q1[c].delete();
                end else begin
                    if (ev2 && ir[c]) void'(q2[c].pop_front());
                    if (iv[c] && er2) q2[c].push_back(fl[8*c +: 8]);
                    if (ev1 && ir[c]) void'(q1[c].pop_front());
                    if (iv[c] && er1) q1[c].push_back(fl[8*c +: 8]);
                end
            end
            next();
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; iv = 2'b00; ir = 2'b00; fl = 16'h0000;
        next();
        test_reset();
        test_stream();
        test_backpressure();
        test_mode1_toggle();
        test_clear();
        test_reset_midstream();
        test_mode0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
